// File: rtl/inst_buffer_if.sv
// Fetch/dispatch-side bundle for inst_buffer, plus the shared packet type and width macros.
// throttle_cycles exists only when INST_BUFFER_PERF_EN is defined.
`ifndef INST_BUFFER_TYPES_DEFINED
`define INST_BUFFER_TYPES_DEFINED
`ifndef N
`define N 3
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS 2
`endif
typedef struct packed {
  logic [31:0] pc;
  logic [31:0] inst;
} FETCH_PACKET;
`endif

interface inst_buffer_if;
  FETCH_PACKET                 inst_buffer_inputs [`N];
  logic [`NUM_SCALAR_BITS-1:0] inst_valid;
  logic [`NUM_SCALAR_BITS-1:0] inst_buffer_spots;
  logic                        restore_valid;
  FETCH_PACKET                 dispatch_packets [`N];
  logic [`NUM_SCALAR_BITS-1:0] dispatch_valid;
  logic [`NUM_SCALAR_BITS-1:0] dispatch_count;
`ifdef INST_BUFFER_PERF_EN
  logic [31:0]                 throttle_cycles;
`endif

  modport master (
    output inst_buffer_inputs,
    output inst_valid,
    output restore_valid,
    output dispatch_count,
    input  inst_buffer_spots,
    input  dispatch_packets,
    input  dispatch_valid
`ifdef INST_BUFFER_PERF_EN
    ,
    input  throttle_cycles
`endif
  );

  modport slave (
    input  inst_buffer_inputs,
    input  inst_valid,
    input  restore_valid,
    input  dispatch_count,
    output inst_buffer_spots,
    output dispatch_packets,
    output dispatch_valid
`ifdef INST_BUFFER_PERF_EN
    ,
    output throttle_cycles
`endif
  );
endinterface

// File: rtl/inst_buffer.sv
// Circular instruction FIFO between fetch and dispatch, up to `N packets in/out per cycle.
// Define INST_BUFFER_PERF_EN to add the saturating throttle_cycles counter.
`ifndef INST_BUFFER_TYPES_DEFINED
`define INST_BUFFER_TYPES_DEFINED
`ifndef N
`define N 3
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS 2
`endif
typedef struct packed {
  logic [31:0] pc;
  logic [31:0] inst;
} FETCH_PACKET;
`endif

module inst_buffer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned PTR_BITS = $clog2(DEPTH)
) (
  input logic          clock,
  input logic          reset,
  inst_buffer_if.slave bus
);
  localparam int unsigned CntBits    = $clog2(DEPTH + 1);
  localparam int unsigned ScalarBits = `NUM_SCALAR_BITS;

  logic [PTR_BITS-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CntBits-1:0]    count_q, count_d, free;
  logic [ScalarBits-1:0] spots, avail, enq, deq;
  FETCH_PACKET           mem_q [DEPTH];
  FETCH_PACKET           mem_d [DEPTH];

  // Credits come from registered count only; a same-cycle dequeue frees nothing yet.
  always_comb begin
    free  = CntBits'(DEPTH) - count_q;
    spots = (free >= CntBits'(`N)) ? ScalarBits'(`N) : ScalarBits'(free);
    avail = (count_q >= CntBits'(`N)) ? ScalarBits'(`N) : ScalarBits'(count_q);
    enq   = (bus.inst_valid < spots) ? bus.inst_valid : spots;
    deq   = (bus.dispatch_count < avail) ? bus.dispatch_count : avail;
  end

  assign bus.inst_buffer_spots = spots;
  assign bus.dispatch_valid    = avail;

  always_comb begin
    head_d  = head_q + PTR_BITS'(deq);
    tail_d  = tail_q + PTR_BITS'(enq);
    count_d = count_q + CntBits'(enq) - CntBits'(deq);
    if (bus.restore_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer arithmetic wraps on its own since DEPTH is a power of two.
  always_comb begin
    mem_d = mem_q;
    if (!bus.restore_valid) begin
      for (int unsigned i = 0; i < `N; i++) begin
        if (i < 32'(enq)) begin
          mem_d[tail_q + PTR_BITS'(i)] = bus.inst_buffer_inputs[i];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < `N; i++) begin
      bus.dispatch_packets[i] = (i < 32'(avail)) ? mem_q[head_q + PTR_BITS'(i)] : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: every output slot is masked by dispatch_valid.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

`ifdef INST_BUFFER_PERF_EN
  logic [31:0] throttle_q, throttle_d;

  always_comb begin
    throttle_d = throttle_q;
    if (!bus.restore_valid && (bus.inst_valid > spots) && (throttle_q != '1)) begin
      throttle_d = throttle_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      throttle_q <= '0;
    end else begin
      throttle_q <= throttle_d;
    end
  end

  assign bus.throttle_cycles = throttle_q;
`endif
endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: queue-based reference model checked every cycle on the
// falling edge, plus literal checks at the interesting corners.
module tb_inst_buffer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  inst_buffer_if ibus ();

  inst_buffer #(.DEPTH(16)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (ibus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic FETCH_PACKET mk(input int unsigned pc);
    FETCH_PACKET p;
    p.pc   = pc;
    p.inst = pc ^ 32'hdead_beef;
    return p;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference model: an ordered list of buffered packets.
  FETCH_PACKET mq[$];
  int unsigned thr = 0;
  bit          live = 0;

  always @(posedge clock) begin
    int sp, en, dv, dq;
    sp = min2(16 - mq.size(), 3);
    dv = min2(mq.size(), 3);
    en = min2(int'(ibus.inst_valid), sp);
    dq = min2(int'(ibus.dispatch_count), dv);
    if (reset) begin
      mq.delete();
      thr  = 0;
      live = 1;
    end else if (ibus.restore_valid) begin
      mq.delete();
    end else begin
      if (int'(ibus.inst_valid) > sp && thr != 32'hffff_ffff) thr++;
      for (int i = 0; i < dq; i++) void'(mq.pop_front());
      for (int i = 0; i < en; i++) mq.push_back(ibus.inst_buffer_inputs[i]);
    end
  end

  always @(negedge clock) begin
    if (live) begin
      int sz;
      sz = mq.size();
      chk("spots", 64'(ibus.inst_buffer_spots), 64'(min2(16 - sz, 3)));
      chk("dvalid", 64'(ibus.dispatch_valid), 64'(min2(sz, 3)));
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("pkt%0d", i), ibus.dispatch_packets[i], (i < sz) ? mq[i] : 64'd0);
      end
`ifdef INST_BUFFER_PERF_EN
      chk("throttle", 64'(ibus.throttle_cycles), 64'(thr));
`endif
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int n, input int unsigned base);
    ibus.inst_valid = 2'(n);
    for (int i = 0; i < 3; i++) ibus.inst_buffer_inputs[i] = mk(base + 32'(4 * i));
  endtask

  initial begin
    ibus.restore_valid  = 1'b0;
    ibus.dispatch_count = '0;
    drive(0, 0);
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;

    // Reset state, and nothing visible before the enqueue edge.
    @(negedge clock);
    chk("rst_spots", 64'(ibus.inst_buffer_spots), 64'd3);
    chk("rst_dv", 64'(ibus.dispatch_valid), 64'd0);
    chk("rst_pkt0", ibus.dispatch_packets[0], 64'd0);
    drive(3, 32'h100);
    cyc();
    drive(0, 0);
    @(negedge clock);
    chk("a_dv", 64'(ibus.dispatch_valid), 64'd3);
    chk("a_pc0", 64'(ibus.dispatch_packets[0].pc), 64'h100);
    chk("a_pc1", 64'(ibus.dispatch_packets[1].pc), 64'h104);
    chk("a_pc2", 64'(ibus.dispatch_packets[2].pc), 64'h108);
    chk("a_spots", 64'(ibus.inst_buffer_spots), 64'd3);
    ibus.dispatch_count = 2'd3;
    cyc();
    ibus.dispatch_count = 2'd0;

    // Fill to 16 without throttling, then offer 2 per cycle for 5 full cycles.
    for (int c = 0; c < 6; c++) begin
      drive((c < 5) ? 3 : 1, 32'h200 + 32'(12 * c));
      cyc();
    end
    for (int c = 0; c < 5; c++) begin
      drive(2, 32'h900 + 32'(8 * c));
      cyc();
    end
    drive(0, 0);
    @(negedge clock);
    chk("full_spots", 64'(ibus.inst_buffer_spots), 64'd0);
    chk("full_size", 64'(mq.size()), 64'd16);
    chk("full_pc0", 64'(ibus.dispatch_packets[0].pc), 64'h200);
`ifdef INST_BUFFER_PERF_EN
    chk("thr5", 64'(ibus.throttle_cycles), 64'd5);
`endif

    // count 15, then enq limited to 1 while 3 leave.
    ibus.dispatch_count = 2'd1;
    cyc();
    ibus.dispatch_count = 2'd3;
    drive(3, 32'h300);
    cyc();
    drive(0, 0);
    ibus.dispatch_count = 2'd0;
    @(negedge clock);
    chk("c13_size", 64'(mq.size()), 64'd13);
    chk("c13_spots", 64'(ibus.inst_buffer_spots), 64'd3);
    chk("c13_pc0", 64'(ibus.dispatch_packets[0].pc), 64'h210);

    // Down to 9, then flush with concurrent enqueue/dequeue.
    ibus.dispatch_count = 2'd3;
    cyc();
    ibus.dispatch_count = 2'd1;
    cyc();
    @(negedge clock);
    chk("c9_size", 64'(mq.size()), 64'd9);
    ibus.restore_valid  = 1'b1;
    ibus.dispatch_count = 2'd2;
    drive(3, 32'h400);
    cyc();
    ibus.restore_valid  = 1'b0;
    ibus.dispatch_count = 2'd0;
    drive(0, 0);
    @(negedge clock);
    chk("rs_dv", 64'(ibus.dispatch_valid), 64'd0);
    chk("rs_spots", 64'(ibus.inst_buffer_spots), 64'd3);
    chk("rs_size", 64'(mq.size()), 64'd0);

    // Move head/tail to 14, then enqueue 3 across the wrap.
    for (int c = 0; c < 5; c++) begin
      drive((c < 4) ? 3 : 2, 32'h700 + 32'(12 * c));
      cyc();
    end
    drive(0, 0);
    for (int c = 0; c < 5; c++) begin
      ibus.dispatch_count = (c < 4) ? 2'd3 : 2'd2;
      cyc();
    end
    ibus.dispatch_count = 2'd0;
    drive(3, 32'h500);
    cyc();
    drive(0, 0);
    @(negedge clock);
    chk("w_pc0", 64'(ibus.dispatch_packets[0].pc), 64'h500);
    chk("w_pc1", 64'(ibus.dispatch_packets[1].pc), 64'h504);
    chk("w_pc2", 64'(ibus.dispatch_packets[2].pc), 64'h508);
    ibus.dispatch_count = 2'd3;
    cyc();
    ibus.dispatch_count = 2'd0;
    drive(1, 32'h600);
    cyc();
    drive(0, 0);
    @(negedge clock);
    chk("w_next", ibus.dispatch_packets[0], mk(32'h600));
    chk("w_dv1", 64'(ibus.dispatch_valid), 64'd1);

    // Mixed traffic with one flush in the middle.
    for (int k = 0; k < 40; k++) begin
      drive(k % 4, 32'h1000 + 32'(16 * k));
      ibus.dispatch_count = 2'((3 * k + 1) % 4);
      ibus.restore_valid  = (k == 25);
      cyc();
    end
    ibus.restore_valid  = 1'b0;
    ibus.dispatch_count = 2'd0;

    // Reset mid-operation: buffered packets must never reappear.
    drive(3, 32'h2000);
    cyc();
    reset = 1'b1;
    drive(3, 32'h2100);
    cyc();
    reset = 1'b0;
    drive(0, 0);
    @(negedge clock);
    chk("mr_dv", 64'(ibus.dispatch_valid), 64'd0);
    drive(2, 32'h3000);
    cyc();
    drive(0, 0);
    @(negedge clock);
    chk("mr_pc0", 64'(ibus.dispatch_packets[0].pc), 64'h3000);
    chk("mr_dv2", 64'(ibus.dispatch_valid), 64'd2);
    ibus.dispatch_count = 2'd3;
    cyc();
    cyc();
    ibus.dispatch_count = 2'd0;

    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
